// File: rtl/retospect_cfg_loader.sv
// Configuration sequencer: takes host bytes over valid/ready and shifts them LSB-first onto the
// fabric config chain, then pulses reset_nn. Define RETOSPECT_CFG_READBACK_EN for the readback CRC.
module retospect_cfg_loader #(
  parameter int CHAIN_LEN = 998,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       config_en,
  output logic       chain_head,
  input  logic       chain_tail,
  output logic       reset_nn,
  output logic       busy,
  output logic       done,
  output logic [7:0] readback_crc
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    NNRST,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       sh_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       byte_bits;
  logic [31:0]      remaining;
  logic [3:0]       fetch_bits;

  // Bits still owed to the chain; the final byte may carry fewer than eight.
  assign remaining  = 32'(CHAIN_LEN) - 32'(bit_cnt);
  assign fetch_bits = (remaining >= 32'd8) ? 4'd8 : remaining[3:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sh_reg    <= 8'h00;
      bit_cnt   <= '0;
      byte_bits <= 4'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) bit_cnt <= '0;
        end
        FETCH: begin
          if (in_valid) begin
            sh_reg    <= in_data;
            byte_bits <= fetch_bits;
          end
        end
        SHIFT: begin
          sh_reg    <= {1'b0, sh_reg[7:1]};
          bit_cnt   <= bit_cnt + CNT_W'(1);
          byte_bits <= byte_bits - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    config_en = 1'b0;
    reset_nn  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        config_en = 1'b1;
        if (byte_bits == 4'd1) state_nxt = (bit_cnt == LAST_BIT) ? NNRST : FETCH;
      end
      NNRST: begin
        reset_nn  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated so the chain head reads 0 whenever the chain is not shifting.
  assign chain_head = (state == SHIFT) & sh_reg[0];

`ifdef RETOSPECT_CFG_READBACK_EN
  logic [7:0] crc_acc;
  logic [7:0] crc_out;
  logic       crc_fb;

  assign crc_fb = crc_acc[7] ^ chain_tail;

  // crc_acc runs during the load; crc_out only publishes the finished signature.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_acc <= 8'h00;
      crc_out <= 8'h00;
    end else begin
      if (state == IDLE && start) begin
        crc_acc <= 8'h00;
        crc_out <= 8'h00;
      end else if (state == SHIFT) begin
        crc_acc <= {crc_acc[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
      end
      if (state == NNRST) crc_out <= crc_acc;
    end
  end

  assign readback_crc = crc_out;
`else
  logic unused_chain_tail;
  assign unused_chain_tail = chain_tail;
  assign readback_crc      = 8'h00;
`endif

endmodule

// File: tb/tb_retospect_cfg_loader.sv
// Bench for retospect_cfg_loader: a 12-bit chain instance drives the scoreboard and the
// vector table; an 8-bit chain instance on the same stimulus covers the whole-byte boundary.
module tb_retospect_cfg_loader;

  localparam int CL = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       chain_tail = 1'b0;

  logic       in_ready, config_en, chain_head, reset_nn, busy, done;
  logic [7:0] readback_crc;
  logic       in_ready8, config_en8, chain_head8, reset_nn8, busy8, done8;
  logic [7:0] readback_crc8;

  int n_checks = 0;
  int n_err    = 0;
  int sent     = 0;
  int hs_cnt   = 0;
  logic sb[$];

  typedef struct {
    logic [7:0]  b0, b1, extra;
    int          gap, stray_start, done_at;
    logic        tail;
    bit          offer_extra;
    logic [31:0] exp_ce;
    logic [7:0]  crc12, crc8;
  } vec_t;

  vec_t vecs[4];

  retospect_cfg_loader #(.CHAIN_LEN(CL), .CNT_W(8)) u_dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .config_en(config_en), .chain_head(chain_head),
    .chain_tail(chain_tail), .reset_nn(reset_nn), .busy(busy), .done(done),
    .readback_crc(readback_crc)
  );

  retospect_cfg_loader #(.CHAIN_LEN(8), .CNT_W(4)) u_dut8 (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready8), .config_en(config_en8), .chain_head(chain_head8),
    .chain_tail(chain_tail), .reset_nn(reset_nn8), .busy(busy8), .done(done8),
    .readback_crc(readback_crc8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: every shift cycle must match the next queued bit.
  always @(negedge clk) begin
    if (config_en) begin
      check("shift_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("chain_head", 32'(chain_head), 32'(sb.pop_front()));
    end
    if (in_valid && in_ready) hs_cnt++;
  end

  // Offer a byte and, once accepted, queue the bits the chain should see.
  task automatic send_byte(input logic [7:0] b);
    bit got = 1'b0;
    int n;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 60 && !got; t++) begin
      if (in_ready) got = 1'b1;
      else @(negedge clk);
    end
    check("handshake_seen", 32'(got), 32'd1);
    if (got) begin
      n = (CL - sent > 8) ? 8 : CL - sent;
      for (int i = 0; i < n; i++) sb.push_back(b[i]);
      sent += n;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] ce_h, rn_h, dn_h, bs_h, dn8_h;
    logic [7:0]  exp12, exp8;
    sent       = 0;
    hs_cnt     = 0;
    chain_tail = v.tail;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("crc_cleared_on_start", 32'(readback_crc), 32'd0);
    check("in_ready_after_start", 32'(in_ready), 32'd1);
    fork
      begin
        send_byte(v.b0);
        repeat (v.gap) @(negedge clk);
        send_byte(v.b1);
        if (v.offer_extra) begin
          in_data  = v.extra;
          in_valid = 1'b1;
          repeat (12) @(negedge clk);
          in_valid = 1'b0;
        end
      end
      begin
        for (int i = 0; i < 32; i++) begin
          start    = (i == v.stray_start);
          ce_h[i]  = config_en;
          rn_h[i]  = reset_nn;
          dn_h[i]  = done;
          bs_h[i]  = busy;
          dn8_h[i] = done8;
          @(negedge clk);
        end
        start = 1'b0;
      end
    join
`ifdef RETOSPECT_CFG_READBACK_EN
    exp12 = v.crc12;
    exp8  = v.crc8;
`else
    exp12 = 8'h00;
    exp8  = 8'h00;
`endif
    check("config_en_trace", ce_h, v.exp_ce);
    check("reset_nn_pulse", rn_h, 32'd1 << (v.done_at - 1));
    check("done_pulse", dn_h, 32'd1 << v.done_at);
    check("busy_trace", bs_h, (32'd1 << (v.done_at + 1)) - 32'd1);
    check("done8_pulse", dn8_h, 32'd1 << 10);
    check("bytes_accepted", 32'(hs_cnt), 32'd2);
    check("bits_left_unshifted", 32'(sb.size()), 32'd0);
    check("readback_crc", 32'(readback_crc), 32'(exp12));
    check("readback_crc8", 32'(readback_crc8), 32'(exp8));
  endtask

  initial begin
    vecs[0] = '{8'hA5, 8'h0F, 8'h00,  0, -1, 15, 1'b0, 1'b0, 32'h0000_3DFE, 8'h00, 8'h00};
    vecs[1] = '{8'h3C, 8'hC3, 8'h00, 20, -1, 27, 1'b1, 1'b0, 32'h03C0_01FE, 8'h30, 8'hF3};
    vecs[2] = '{8'hFF, 8'h01, 8'h00,  0,  4, 15, 1'b1, 1'b0, 32'h0000_3DFE, 8'h30, 8'hF3};
    vecs[3] = '{8'h5A, 8'hE7, 8'hC3,  3, -1, 15, 1'b0, 1'b1, 32'h0000_3DFE, 8'h00, 8'h00};

    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_config_en", 32'(config_en), 32'd0);
    check("rst_reset_nn", 32'(reset_nn), 32'd0);
    check("rst_busy_done", 32'({busy, done, chain_head}), 32'd0);
    check("rst_crc", 32'(readback_crc), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    for (int k = 0; k < 4; k++) run_load(vecs[k]);

    // Reset landing on the third shift cycle aborts the load.
    sent = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_byte(8'h11);
    @(negedge clk);
    @(negedge clk);
    check("third_shift_active", 32'(config_en), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_config_en", 32'(config_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    reset = 1'b0;
    @(negedge clk);
    check("abort_idle_in_ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("restart_in_ready", 32'(in_ready), 32'd1);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
